muldiv_seq: RTL

- Iterative RV32M multiply/divide sequencer beside the single-cycle ALU in the execute stage.
- Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request at a time.
- Runs a 32-step shift-add (multiply) or restoring shift-subtract (divide) loop on an internal 33-bit adder. The adder is built as a + ~b + 1, with no '-' operator.
- Returns the 32-bit result and a destination tag to writeback over a valid/ready handshake.

---
 rtl/muldiv_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the execute stage.
// Runs a 32-step shift-add / restoring shift-subtract loop on one shared 33-bit adder.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_op_i,
  input  logic [XLEN-1:0]  req_a_i,
  input  logic [XLEN-1:0]  req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             busy_o
);

  localparam int AW = XLEN + 1;
  localparam int PW = 2 * XLEN;
  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
  } req_t;

  state_t           state, state_nxt;
  req_t             req_q;
  logic             sa_q, sb_q;
  logic [XLEN-1:0]  b_abs_q;
  logic [PW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             is_div, signed_a, signed_b, a_neg, b_neg;
  logic [XLEN-1:0]  a_abs, b_abs;
  logic [AW-1:0]    add_x, add_y, add_s;
  logic             add_sub;
  logic [PW-1:0]    step_acc;
  logic [PW-1:0]    prod;
  logic [XLEN-1:0]  quo, rem, fix_data;
  logic             div0, ovf;

  assign accept       = req_valid_i & req_ready_o & ~flush_i;
  assign req_ready_o  = (state == S_IDLE);
  assign resp_valid_o = (state == S_DONE);
  assign busy_o       = (state != S_IDLE);

  // Operand sign handling; MUL low word is sign-independent so it skips this.
  assign is_div   = req_q.op[2];
  assign signed_a = (req_q.op == OP_MULH) | (req_q.op == OP_MULHSU) |
                    (req_q.op == OP_DIV)  | (req_q.op == OP_REM);
  assign signed_b = (req_q.op == OP_MULH) | (req_q.op == OP_DIV) | (req_q.op == OP_REM);
  assign a_neg    = signed_a & req_q.a[XLEN-1];
  assign b_neg    = signed_b & req_q.b[XLEN-1];
  assign a_abs    = a_neg ? (~req_q.a + XLEN'(1)) : req_q.a;
  assign b_abs    = b_neg ? (~req_q.b + XLEN'(1)) : req_q.b;

  // Shared 33-bit adder: x + y, or x + ~y + 1 for the divide trial subtract.
  always_comb begin
    add_sub = is_div;
    add_y   = {1'b0, b_abs_q};
    add_x   = is_div ? acc_q[PW-1:XLEN-1] : {1'b0, acc_q[PW-1:XLEN]};
    add_s   = add_x + (add_sub ? ~add_y : add_y) + AW'(add_sub);
  end

  // One loop iteration. Divide remainder stays below the divisor, so bit 32
  // of the 33-bit difference is a clean borrow flag.
  always_comb begin
    step_acc = acc_q;
    if (is_div) begin
      if (!add_s[XLEN]) step_acc = {add_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else              step_acc = {acc_q[PW-2:0], 1'b0};
    end else begin
      if (acc_q[0]) step_acc = {add_s, acc_q[XLEN-1:1]};
      else          step_acc = {1'b0, acc_q[PW-1:1]};
    end
  end

  // Sign correction and architectural special cases.
  always_comb begin
    prod = (sa_q ^ sb_q) ? (~acc_q + PW'(1)) : acc_q;
    quo  = (sa_q ^ sb_q) ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
    rem  = sa_q ? (~acc_q[PW-1:XLEN] + XLEN'(1)) : acc_q[PW-1:XLEN];
    div0 = (req_q.b == '0);
    ovf  = ((req_q.op == OP_DIV) | (req_q.op == OP_REM)) &
           (req_q.a == {1'b1, {(XLEN-1){1'b0}}}) & (req_q.b == '1);
    case (req_q.op)
      OP_MUL:                       fix_data = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_data = prod[PW-1:XLEN];
      OP_DIV, OP_DIVU:              fix_data = quo;
      default:                      fix_data = rem;
    endcase
    if (is_div && div0) begin
      fix_data = ((req_q.op == OP_DIV) | (req_q.op == OP_DIVU)) ? '1 : req_q.a;
    end else if (ovf) begin
      fix_data = (req_q.op == OP_DIV) ? req_q.a : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_PREP;
      S_PREP: state_nxt = S_CALC;
      S_CALC: if (cnt_q == CW'(XLEN-1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: if (resp_ready_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush_i) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      b_abs_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      resp_data_o <= '0;
      resp_tag_o  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) req_q <= '{op: req_op_i, a: req_a_i, b: req_b_i, tag: req_tag_i};
        end
        S_PREP: begin
          sa_q    <= a_neg;
          sb_q    <= b_neg;
          b_abs_q <= b_abs;
          acc_q   <= {{XLEN{1'b0}}, a_abs};
          cnt_q   <= '0;
        end
        S_CALC: begin
          acc_q <= step_acc;
          cnt_q <= cnt_q + CW'(1);
        end
        S_FIX: begin
          resp_data_o <= fix_data;
          resp_tag_o  <= req_q.tag;
        end
        default: ;
      endcase
    end
  end

endmodule
